// File: rtl/spart_rx.sv
// SPART receiver: 8N1 deserializer sampling mid-bit from an oversampled baud enable.
// Optional framing-error flag output `ferr` is built when SPART_RX_FERR_EN is defined.
//
// state   | meaning
// S_IDLE  | line idle, waiting for a falling edge on the synchronized input
// S_START | timing to mid start bit to confirm a real start (reject glitches)
// S_DATA  | sampling 8 data bits LSB first, one per OVERSAMPLE ticks
// S_STOP  | sampling the stop bit; good frames update rx_data and rda

module spart_rx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sample_en,
   input  logic       rxd,
   input  logic       clr_rda,
   output logic [7:0] rx_data,
   output logic       rda
`ifdef SPART_RX_FERR_EN
   ,
   output logic       ferr
`endif
);

   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic            r_rxd_meta;
   logic            r_rxd_s;
   logic            r_rxd_prev;
   logic [CW-1:0]   r_smp_cnt;
   logic [2:0]      r_bit_cnt;
   logic [7:0]      r_shift;
   logic [7:0]      r_rx_data;
   logic            r_rda;

   logic            w_fall;
   logic            w_cnt_clr;
   logic            w_cnt_inc;
   logic            w_bit_clr;
   logic            w_bit_inc;
   logic            w_shift_en;
   logic            w_stop_smp;
   logic            w_good;

   assign w_fall = r_rxd_prev & ~r_rxd_s;

   // Two-flop synchronizer plus a history flop for falling-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rxd_meta <= 1'b1;
         r_rxd_s    <= 1'b1;
         r_rxd_prev <= 1'b1;
      end else begin
         r_rxd_meta <= rxd;
         r_rxd_s    <= r_rxd_meta;
         r_rxd_prev <= r_rxd_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      w_bit_clr   = 1'b0;
      w_bit_inc   = 1'b0;
      w_shift_en  = 1'b0;
      w_stop_smp  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_fall) begin
               w_state_nxt = S_START;
               w_cnt_clr   = 1'b1;
            end
         end
         S_START: begin
            if (sample_en) begin
               if (r_smp_cnt == MID_CNT) begin
                  w_cnt_clr = 1'b1;
                  if (!r_rxd_s) begin
                     w_state_nxt = S_DATA;
                     w_bit_clr   = 1'b1;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (sample_en) begin
               if (r_smp_cnt == LAST_CNT) begin
                  w_cnt_clr  = 1'b1;
                  w_shift_en = 1'b1;
                  if (r_bit_cnt == 3'd7) begin
                     w_state_nxt = S_STOP;
                  end else begin
                     w_bit_inc = 1'b1;
                  end
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
         end
         S_STOP: begin
            if (sample_en) begin
               if (r_smp_cnt == LAST_CNT) begin
                  w_cnt_clr   = 1'b1;
                  w_stop_smp  = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_clr   = 1'b1;
         end
      endcase
   end

   assign w_good = w_stop_smp & r_rxd_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_smp_cnt <= '0;
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'h00;
      end else begin
         if (w_cnt_clr) begin
            r_smp_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_smp_cnt <= r_smp_cnt + CW'(1);
         end
         if (w_bit_clr) begin
            r_bit_cnt <= 3'd0;
         end else if (w_bit_inc) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         if (w_shift_en) begin
            r_shift <= {r_rxd_s, r_shift[7:1]};
         end
      end
   end

   // A set on the same edge as clr_rda wins, so a fresh byte is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_data <= 8'h00;
         r_rda     <= 1'b0;
      end else begin
         if (w_good) begin
            r_rx_data <= r_shift;
            r_rda     <= 1'b1;
         end else if (clr_rda) begin
            r_rda <= 1'b0;
         end
      end
   end

   assign rx_data = r_rx_data;
   assign rda     = r_rda;

`ifdef SPART_RX_FERR_EN
   logic r_ferr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ferr <= 1'b0;
      end else begin
         if (w_stop_smp && !r_rxd_s) begin
            r_ferr <= 1'b1;
         end else if (clr_rda) begin
            r_ferr <= 1'b0;
         end
      end
   end

   assign ferr = r_ferr;
`endif

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: serial frames driven bit by bit, expected bytes queued at send
// time and popped by an independent monitor whenever the receiver presents a byte.

module tb_spart_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sample_en = 1'b0;
   logic       rxd = 1'b1;
   logic       clr_rda = 1'b0;
   logic [7:0] rx_data;
   logic       rda;
`ifdef SPART_RX_FERR_EN
   logic       ferr;
`endif

   int          tests = 0;
   int          fails = 0;
   int unsigned g_edge = 0;
   logic [7:0]  exp_q[$];
   bit          done = 1'b0;

   int          rise_edge;
   bit          rise_tick;
   int          lows;
   bit          tie_seen;

   logic        m_prv_rda = 1'b0;
   logic [7:0]  m_prv_data = 8'h00;
   logic [7:0]  m_exp;

   logic [7:0]  last_good;
   logic [7:0]  rb;
   logic        rstop;
   int          gap;

   spart_rx #(.OVERSAMPLE(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .rxd       (rxd),
      .clr_rda   (clr_rda),
      .rx_data   (rx_data),
      .rda       (rda)
`ifdef SPART_RX_FERR_EN
      ,
      .ferr      (ferr)
`endif
   );

   initial forever #5 clk = ~clk;

   // sample_en is high on every 4th rising edge; updated just after each edge.
   initial forever begin
      @(posedge clk);
      g_edge++;
      #1 sample_en = ((g_edge + 1) % 4 == 0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clr();
      clr_rda = 1'b1;
      @(negedge clk);
      clr_rda = 1'b0;
   endtask

   // Drives nbits of an 8N1 frame, 64 clk per bit, and records when rda rose.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits,
                             input bit chk_hi, input bit tie);
      logic [9:0] fr;
      int         n;
      logic       prv;
      logic       se;
      logic       clr_now;
      fr = {stop, b, 1'b0};
      if (nbits == 10 && stop) exp_q.push_back(b);
      rise_edge = 0;
      rise_tick = 1'b0;
      lows      = 0;
      tie_seen  = 1'b0;
      n         = 0;
      prv       = rda;
      for (int i = 0; i < nbits; i++) begin
         rxd = fr[i];
         for (int c = 0; c < 64; c++) begin
            clr_now = clr_rda;
            @(posedge clk);
            n++;
            se = sample_en;
            @(negedge clk);
            if (rda && !prv && rise_edge == 0) begin
               rise_edge = n;
               rise_tick = se;
               if (tie && clr_now) tie_seen = 1'b1;
            end
            prv = rda;
            if (chk_hi && !rda) lows++;
            if (tie) clr_rda = (!tie_seen && n >= 596 && n <= 624) ? sample_en : 1'b0;
         end
      end
      clr_rda = 1'b0;
   endtask

   // Monitor: a byte is presented when rda rises or rx_data changes while rda is held.
   initial begin
      while (!done) begin
         @(negedge clk);
         if (rst_n && rda && (!m_prv_rda || rx_data != m_prv_data)) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_unexpected: got byte 0x%0h, expected no byte", rx_data);
            end else begin
               m_exp = exp_q.pop_front();
               check("sb_data", {24'h0, rx_data}, {24'h0, m_exp});
            end
         end
         m_prv_rda  = rda;
         m_prv_data = rx_data;
      end
   end

   initial begin
      #3000000;
      tests++;
      fails++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_rx_data", {24'h0, rx_data}, 32'h00);
      check("rst_rda", {31'h0, rda}, 32'h0);
`ifdef SPART_RX_FERR_EN
      check("rst_ferr", {31'h0, ferr}, 32'h0);
`endif
      rst_n = 1'b1;
      idle(10);

      // Good frame; stop sampled ~9.5 bit times (608 clk) plus up to 3 clk of sync/tick phase.
      send_frame(8'hA5, 1'b1, 10, 1'b0, 1'b0);
      check("a5_rda", {31'h0, rda}, 32'h1);
      check("a5_latency_window", {31'h0, (rise_edge >= 608 && rise_edge <= 611)}, 32'h1);
      check("a5_rise_after_tick", {31'h0, rise_tick}, 32'h1);
      pulse_clr();
      check("a5_clr_rda", {31'h0, rda}, 32'h0);
      check("a5_data_kept", {24'h0, rx_data}, 32'hA5);

      // Glitch shorter than half a bit must be rejected.
      rxd = 1'b0;
      idle(12);
      rxd = 1'b1;
      idle(64);
      check("glitch_rda", {31'h0, rda}, 32'h0);
      send_frame(8'h3C, 1'b1, 10, 1'b0, 1'b0);
      check("3c_rda", {31'h0, rda}, 32'h1);
      pulse_clr();
      check("3c_data", {24'h0, rx_data}, 32'h3C);

      // Framing error, then line held low for 20 bit times.
      send_frame(8'h7E, 1'b0, 10, 1'b0, 1'b0);
      check("ferr_frame_rda", {31'h0, rda}, 32'h0);
      check("ferr_frame_data", {24'h0, rx_data}, 32'h3C);
`ifdef SPART_RX_FERR_EN
      check("ferr_set", {31'h0, ferr}, 32'h1);
`endif
      idle(20 * 64);
      check("low_hold_rda", {31'h0, rda}, 32'h0);
      rxd = 1'b1;
      idle(64);
      pulse_clr();
`ifdef SPART_RX_FERR_EN
      check("ferr_cleared", {31'h0, ferr}, 32'h0);
`endif
      send_frame(8'h96, 1'b1, 10, 1'b0, 1'b0);
      check("after_low_data", {24'h0, rx_data}, 32'h96);
      pulse_clr();

      // Back-to-back frames with overrun: rda never drops.
      send_frame(8'h01, 1'b1, 10, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 10, 1'b1, 1'b0);
      check("b2b_rda_low_cycles", lows, 0);
      check("b2b_data", {24'h0, rx_data}, 32'hFF);

      // Reset after 4 data bits of 0xC3.
      send_frame(8'hC3, 1'b1, 5, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_data", {24'h0, rx_data}, 32'h00);
      check("midrst_rda", {31'h0, rda}, 32'h0);
      rxd = 1'b1;
      @(negedge clk);
      idle(3);
      rst_n = 1'b1;
      idle(64);
      send_frame(8'h5A, 1'b1, 10, 1'b0, 1'b0);
      check("post_rst_data", {24'h0, rx_data}, 32'h5A);
      pulse_clr();

      // clr_rda on every tick around the stop sample: the set edge must coincide and win.
      send_frame(8'h42, 1'b1, 10, 1'b0, 1'b1);
      check("tie_seen", {31'h0, tie_seen}, 32'h1);
      check("tie_rda", {31'h0, rda}, 32'h1);
      pulse_clr();
      last_good = 8'h42;

      for (int k = 0; k < 25; k++) begin
         rb    = 8'($urandom_range(0, 255));
         rstop = ($urandom_range(0, 4) != 0);
         send_frame(rb, rstop, 10, 1'b0, 1'b0);
         if (rstop) last_good = rb;
         check("rnd_rda", {31'h0, rda}, {31'h0, rstop});
`ifdef SPART_RX_FERR_EN
         check("rnd_ferr", {31'h0, ferr}, {31'h0, ~rstop});
`endif
         rxd = 1'b1;
         pulse_clr();
         check("rnd_clr_rda", {31'h0, rda}, 32'h0);
         check("rnd_data", {24'h0, rx_data}, {24'h0, last_good});
         gap = rstop ? $urandom_range(0, 80) : $urandom_range(16, 80);
         idle(gap);
      end

      idle(5);
      done = 1'b1;
      check("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Receive half of the SPART serial port. Deserializes 8N1 frames on `rxd`: one start bit (0), 8 data bits LSB first, one stop bit (1).
- Presents the received byte with a receive-data-available flag to the bus interface / driver.
- Uses an oversampled baud enable and samples each bit at mid-bit. The baud generator is shared with the transmit side.

Parameters:
- OVERSAMPLE, 16, number of `sample_en` ticks per bit period. Must be even and ≥4.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sample_en  input  1  one-clk-wide enable pulse, OVERSAMPLE pulses per bit time
- rxd  input  1  asynchronous serial input; idles high
- clr_rda  input  1  one-clk pulse from the bus side; byte consumed
- rx_data  output  8  last correctly framed byte
- rda  output  1  receive data available (sticky)

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst_n` is asynchronous, active-low. All flops reset asynchronously.
- Reset values: `rx_data`=8'h00, `rda`=0, state=IDLE, counters=0, shift register=8'h00, synchronizer flops=1.
- Synchronizer: `rxd` passes through two flops (`rxd_s`); a third flop holds the previous value for edge detection. All logic uses `rxd_s` only.
- Sample counter:
  - Width: clog2(OVERSAMPLE).
  - Advances only on `sample_en`.
  - Cleared on every state entry.
- Bit counter: 3 bits, counts data bits 0–7.
- State machine (4 states):
  - IDLE: a falling edge on `rxd_s` (previous 1, now 0) → START, sample counter cleared. A line held low never retriggers.
  - START: on the `sample_en` where sample count reaches OVERSAMPLE/2−1 (mid start bit), check `rxd_s`:
    - 0 → DATA, sample counter and bit counter cleared.
    - 1 → IDLE (glitch rejected; no other effect).
  - DATA: every OVERSAMPLE `sample_en` ticks (mid-bit), shift in: shift ← {rxd_s, shift[7:1]}. After the 8th bit (bit counter = 7) → STOP.
  - STOP: after OVERSAMPLE ticks (mid stop bit), sample `rxd_s`, then → IDLE in all cases.
    - 1: `rx_data` ← shift; `rda` ← 1 on the next clk edge.
    - 0: framing error; byte discarded; `rx_data` and `rda` unchanged.
- Latency: `rda` rises exactly one clk after the `sample_en` tick that samples the stop bit. This is ≈9.5 bit times after the start edge, plus 2–3 clk of synchronizer delay.
- `rda` rules:
  - Set by a good frame; cleared by `clr_rda`.
  - Simultaneous set and `clr_rda` → set wins.
  - Overrun: a good frame arriving while `rda`=1 overwrites `rx_data`, and `rda` stays 1. No error flag.
- `sample_en` absent: state is frozen, except the IDLE edge detect, which runs every clk.
- Reset mid-frame: returns immediately to reset values. A partial frame is lost.

Optional Feature:
- Macro SPART_RX_FERR_EN.
- Defined:
  - Adds output port `ferr` (1 bit, reset 0).
  - `ferr` is set one clk after a stop-bit sample of 0.
  - `ferr` is cleared by `clr_rda`; set wins on a tie.
  - A good frame does not clear `ferr`.
- Undefined: no `ferr` port and no associated flop; framing errors are silently discarded as above.

Test Plan:
- Bench conditions: OVERSAMPLE=16, `sample_en` every 4 clk, bit time = 64 clk.
- Good frame: send 8'hA5 as 8N1 → `rx_data`=8'hA5, `rda`=1 one clk after the stop sample tick. Then pulse `clr_rda` → `rda`=0 next clk; `rx_data` remains 8'hA5.
- Glitch: drive `rxd` low for 12 clk, then high → FSM returns to IDLE from START; `rda` stays 0. A following 8'h3C frame is received correctly.
- Framing error: send 8'h7E with the stop bit driven 0 → `rda` stays 0 and `rx_data` is unchanged.
  - With SPART_RX_FERR_EN: `ferr`=1; pulse `clr_rda` → `ferr`=0.
- Back-to-back and overrun: send 8'h01 then 8'hFF with no idle gap and no `clr_rda` → `rda`=1 throughout, final `rx_data`=8'hFF. Assert `clr_rda` on the same clk as the second set → `rda`=1.
- Reset mid-frame: assert `rst_n`=0 after 4 data bits of 8'hC3 → all outputs at reset values immediately. Next frame 8'h5A → `rx_data`=8'h5A.
- Line held low: hold `rxd`=0 for 20 bit times after a framing error → no new frame starts until `rxd` returns high and falls again.
